// File: rtl/mips_pkg.sv
// mips_pkg: shared arbiter types for the unified-memory
// arbiter, the hazard logic and the bench.
package mips_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GNT_DM = 2'd1,
    ARB_GNT_IF = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } gnt_t;

endpackage

// File: rtl/mem_arb_if.sv
// mem_arb_if: single-port memory bus between the arbiter
// (master) and the unified memory (slave).
interface mem_arb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/arb_wdog.sv
// arb_wdog: wait-cycle counter for a granted access;
// expired once it has counted TIMEOUT stalled cycles.
module arb_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == W'(TIMEOUT));
endmodule

// File: rtl/mem_arb.sv
// mem_arb: serialises IF fetches and MEM loads/stores onto
// one unified memory port, with alternating tie-break.
import mips_pkg::*;

module mem_arb #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  mem_arb_if.master     mem,
  output logic          stall_if,
  output logic          stall_mem,
  output logic          timeout_err
);
  localparam logic [1:0] IDLE = ARB_IDLE;
  localparam logic [1:0] S_DM = ARB_GNT_DM;
  localparam logic [1:0] S_IF = ARB_GNT_IF;

  logic [1:0] state;
  gnt_t       last_gnt;
  logic       if_ok;
  logic       dm_ok;
  logic       pick_dm;
  logic       grant;
  logic       busy;
  logic       done;
  logic       expired;

  // a requester in its valid cycle is already served
  assign if_ok   = if_req & ~if_valid;
  assign dm_ok   = dm_req & ~dm_valid;
  assign pick_dm = dm_ok & (~if_ok | (last_gnt == GNT_IF));
  assign grant   = (state == IDLE) & (if_ok | dm_ok);
  assign busy    = (state != IDLE);
  assign done    = mem.mem_req & mem.mem_ready;

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = dm_req & ~dm_valid;

  arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (grant),
    .en      (busy & ~mem.mem_ready & ~expired),
    .expired (expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      last_gnt      <= GNT_IF;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      if_valid      <= 1'b0;
      dm_valid      <= 1'b0;
      if_rdata      <= '0;
      dm_rdata      <= '0;
      timeout_err   <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            state         <= pick_dm ? S_DM : S_IF;
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= pick_dm & dm_we;
            mem.mem_addr  <= pick_dm ? dm_addr : if_addr;
            mem.mem_wdata <= pick_dm ? dm_wdata : '0;
          end
        end
        S_DM, S_IF: begin
          // completion wins over a same-cycle watchdog expiry
          if (done | expired) begin
            state         <= IDLE;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            last_gnt      <= (state == S_DM) ? GNT_DM : GNT_IF;
            if (!done) begin
              timeout_err <= 1'b1;
            end
            if (state == S_DM) begin
              dm_valid <= 1'b1;
              dm_rdata <= (done & ~mem.mem_we) ? mem.mem_rdata : '0;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= done ? mem.mem_rdata : '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed scenarios plus a randomized run
// scored against a word-level memory/fairness model.
module tb_mem_arb;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        stall_if;
  logic        stall_mem;
  logic        timeout_err;

  int vectors = 0;
  int miscompares = 0;

  // memory behaviour: -1 random 0..3 waits, -2 never ready
  int lat_mode = 0;
  logic [31:0] ram [logic [31:0]];
  logic [31:0] gmem [logic [31:0]];

  mem_arb_if #(.AW(32), .DW(32)) mem ();

  mem_arb #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_valid    (if_valid),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rdata    (dm_rdata),
    .dm_valid    (dm_valid),
    .mem         (mem),
    .stall_if    (stall_if),
    .stall_mem   (stall_mem),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : init_val(a);
  endfunction

  function automatic logic [31:0] gmem_rd(input logic [31:0] a);
    return gmem.exists(a) ? gmem[a] : init_val(a);
  endfunction

  // memory responder, driven on the falling edge
  initial begin
    int wcnt;
    int cur_lat;
    wcnt = 0;
    cur_lat = 0;
    mem.mem_ready = 1'b0;
    mem.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || !mem.mem_req) begin
        mem.mem_ready = 1'b0;
        mem.mem_rdata = $urandom;
        wcnt = 0;
      end else begin
        if (wcnt == 0) begin
          cur_lat = (lat_mode == -1) ? int'($urandom_range(0, 3)) : lat_mode;
        end
        if (lat_mode != -2 && wcnt >= cur_lat) begin
          mem.mem_ready = 1'b1;
          mem.mem_rdata = mem.mem_we ? $urandom : ram_rd(mem.mem_addr);
          if (mem.mem_we) ram[mem.mem_addr] = mem.mem_wdata;
        end else begin
          mem.mem_ready = 1'b0;
          mem.mem_rdata = $urandom;
        end
        wcnt++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input bit is_dm, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 40) begin
      tick();
      n++;
      seen = is_dm ? dm_valid : if_valid;
    end
    if (!seen) n = -1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    vectors++;
    if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata, if_valid,
         dm_valid, if_rdata, dm_rdata, timeout_err, stall_if,
         stall_mem} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h ifv=%b dmv=%b ifr=%h dmr=%h to=%b expected all 0",
               mem.mem_req, mem.mem_we, mem.mem_addr, if_valid, dm_valid,
               if_rdata, dm_rdata, timeout_err);
    end
    rst_n = 1'b1;
    tick();
    vectors++;
    if (mem.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: got mem_req=%b expected 0", mem.mem_req);
    end
  endtask

  task automatic test_lone_fetch;
    ram[32'h40] = 32'h2008_0005;
    gmem[32'h40] = 32'h2008_0005;
    lat_mode = 0;
    if_addr = 32'h40;
    if_req = 1'b1;
    #1;
    vectors++;
    if (stall_if !== 1'b1) begin
      miscompares++;
      $display("FAIL lone_stall_n: got %b expected 1", stall_if);
    end
    tick();
    vectors++;
    if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata, stall_if, if_valid}
        !== {1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL lone_grant: got req=%b we=%b addr=%h wd=%h stall=%b v=%b expected 1 0 00000040 0 1 0",
               mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata, stall_if, if_valid);
    end
    tick();
    vectors++;
    if ({if_valid, if_rdata, mem.mem_req, stall_if} !== {1'b1, 32'h2008_0005, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL lone_valid: got v=%b rdata=%h req=%b stall=%b expected 1 20080005 0 0",
               if_valid, if_rdata, mem.mem_req, stall_if);
    end
    if_req = 1'b0;
    tick();
    vectors++;
    if ({if_valid, mem.mem_req} !== 2'b00) begin
      miscompares++;
      $display("FAIL lone_pulse: got v=%b req=%b expected 0 0", if_valid, mem.mem_req);
    end
  endtask

  task automatic test_tie;
    int n;
    lat_mode = 0;
    if_addr = 32'h80;
    dm_addr = 32'h300;
    dm_we = 1'b0;
    if_req = 1'b1;
    dm_req = 1'b1;
    tick();
    vectors++;
    if ({mem.mem_req, mem.mem_addr} !== {1'b1, 32'h300}) begin
      miscompares++;
      $display("FAIL tie1_dm_first: got req=%b addr=%h expected 1 00000300", mem.mem_req, mem.mem_addr);
    end
    tick();
    vectors++;
    if ({dm_valid, if_valid, dm_rdata} !== {1'b1, 1'b0, init_val(32'h300)}) begin
      miscompares++;
      $display("FAIL tie1_dm_valid: got dv=%b iv=%b rdata=%h expected 1 0 %h",
               dm_valid, if_valid, dm_rdata, init_val(32'h300));
    end
    dm_req = 1'b0;
    tick();
    vectors++;
    if ({mem.mem_req, mem.mem_addr} !== {1'b1, 32'h80}) begin
      miscompares++;
      $display("FAIL tie1_if_second: got req=%b addr=%h expected 1 00000080", mem.mem_req, mem.mem_addr);
    end
    tick();
    vectors++;
    if ({if_valid, if_rdata} !== {1'b1, init_val(32'h80)}) begin
      miscompares++;
      $display("FAIL tie1_if_valid: got v=%b rdata=%h expected 1 %h", if_valid, if_rdata, init_val(32'h80));
    end
    if_req = 1'b0;
    tick();
    // DM served last -> the next tie belongs to IF
    dm_addr = 32'h304;
    dm_req = 1'b1;
    wait_valid(1'b1, n);
    dm_req = 1'b0;
    tick();
    if_addr = 32'h84;
    dm_addr = 32'h30C;
    if_req = 1'b1;
    dm_req = 1'b1;
    tick();
    vectors++;
    if ({mem.mem_req, mem.mem_addr} !== {1'b1, 32'h84}) begin
      miscompares++;
      $display("FAIL tie2_if_first: got req=%b addr=%h expected 1 00000084", mem.mem_req, mem.mem_addr);
    end
    wait_valid(1'b0, n);
    if_req = 1'b0;
    wait_valid(1'b1, n);
    vectors++;
    if (n != 2 || dm_rdata !== init_val(32'h30C)) begin
      miscompares++;
      $display("FAIL tie2_dm_after: got lat=%0d rdata=%h expected 2 %h", n, dm_rdata, init_val(32'h30C));
    end
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_store;
    int n;
    int wec;
    bit bad;
    n = 0;
    wec = 0;
    bad = 1'b0;
    lat_mode = 3;
    dm_we = 1'b1;
    dm_addr = 32'h100;
    dm_wdata = 32'hDEAD_BEEF;
    dm_req = 1'b1;
    do begin
      tick();
      n++;
      if (mem.mem_req && mem.mem_we) begin
        wec++;
        if (mem.mem_addr !== 32'h100 || mem.mem_wdata !== 32'hDEAD_BEEF) bad = 1'b1;
      end
    end while (!dm_valid && n < 30);
    vectors++;
    if (n != 5) begin
      miscompares++;
      $display("FAIL store_latency: got %0d expected 5", n);
    end
    vectors++;
    if (wec != 4 || bad) begin
      miscompares++;
      $display("FAIL store_bus: got we_cycles=%0d bad=%b expected 4 0", wec, bad);
    end
    vectors++;
    if (dm_rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL store_rdata: got %h expected 00000000", dm_rdata);
    end
    dm_req = 1'b0;
    dm_we = 1'b0;
    lat_mode = 0;
    tick();
  endtask

  task automatic test_timeout;
    int n;
    bit early;
    n = 0;
    early = 1'b0;
    lat_mode = -2;
    dm_we = 1'b0;
    dm_addr = 32'h308;
    dm_req = 1'b1;
    do begin
      tick();
      n++;
      if (timeout_err && !dm_valid) early = 1'b1;
    end while (!dm_valid && n < 40);
    vectors++;
    if (n != 17 || early) begin
      miscompares++;
      $display("FAIL timeout_latency: got %0d early=%b expected 17 0", n, early);
    end
    vectors++;
    if ({timeout_err, dm_rdata} !== {1'b1, 32'h0}) begin
      miscompares++;
      $display("FAIL timeout_abort: got err=%b rdata=%h expected 1 00000000", timeout_err, dm_rdata);
    end
    dm_req = 1'b0;
    lat_mode = 0;
    tick();
    if_addr = 32'h40;
    if_req = 1'b1;
    wait_valid(1'b0, n);
    vectors++;
    if (n != 2 || if_rdata !== 32'h2008_0005 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_recover: got lat=%0d rdata=%h err=%b expected 2 20080005 1",
               n, if_rdata, timeout_err);
    end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid;
    int hits;
    hits = 0;
    lat_mode = -2;
    if_addr = 32'h88;
    if_req = 1'b1;
    tick();
    tick();
    vectors++;
    if (mem.mem_req !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre: got mem_req=%b expected 1", mem.mem_req);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({mem.mem_req, mem.mem_we, mem.mem_addr, mem.mem_wdata, if_valid,
         dm_valid, if_rdata, dm_rdata, timeout_err} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_async: got req=%b addr=%h ifr=%h dmr=%h to=%b expected all 0",
               mem.mem_req, mem.mem_addr, if_rdata, dm_rdata, timeout_err);
    end
    if_req = 1'b0;
    lat_mode = 0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (if_valid || mem.mem_req) hits++;
    end
    vectors++;
    if (hits != 0) begin
      miscompares++;
      $display("FAIL rstmid_no_valid: got %0d active cycles expected 0", hits);
    end
  endtask

  task automatic test_back_to_back;
    int n;
    lat_mode = -1;
    dm_we = 1'b0;
    dm_addr = 32'h100;
    dm_req = 1'b1;
    wait_valid(1'b1, n);
    vectors++;
    if (n < 2 || n > 5 || dm_rdata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL b2b_first: got lat=%0d rdata=%h expected 2..5 deadbeef", n, dm_rdata);
    end
    dm_addr = 32'h308;
    tick();
    vectors++;
    if ({mem.mem_req, dm_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL b2b_no_extra: got req=%b v=%b expected 0 0", mem.mem_req, dm_valid);
    end
    wait_valid(1'b1, n);
    vectors++;
    if (n < 2 || n > 5 || dm_rdata !== init_val(32'h308)) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d rdata=%h expected 2..5 %h", n, dm_rdata, init_val(32'h308));
    end
    dm_req = 1'b0;
    tick();
  endtask

  task automatic test_random;
    int if_wait, dm_wait, if_other, dm_other;
    logic [31:0] exp;
    bit ok;
    if_wait = 0; dm_wait = 0; if_other = 0; dm_other = 0;
    lat_mode = -1;
    for (int c = 0; c < 600; c++) begin
      tick();
      vectors++;
      if (stall_if !== (if_req & ~if_valid) || stall_mem !== (dm_req & ~dm_valid)) begin
        miscompares++;
        $display("FAIL rnd_stall: got %b%b expected %b%b at %0d", stall_if, stall_mem,
                 if_req & ~if_valid, dm_req & ~dm_valid, c);
      end
      vectors++;
      if (if_valid && dm_valid) begin
        miscompares++;
        $display("FAIL rnd_dual_valid: got both valids expected one at %0d", c);
      end
      if (mem.mem_req) begin
        ok = (if_req && !mem.mem_we && mem.mem_addr == if_addr && mem.mem_wdata == 0) ||
             (dm_req && mem.mem_we == dm_we && mem.mem_addr == dm_addr &&
              mem.mem_wdata == dm_wdata);
        vectors++;
        if (!ok) begin
          miscompares++;
          $display("FAIL rnd_bus: got we=%b addr=%h wd=%h expected a pending request at %0d",
                   mem.mem_we, mem.mem_addr, mem.mem_wdata, c);
        end
      end
      if (if_valid) begin
        exp = gmem_rd(if_addr);
        vectors++;
        if (!if_req || if_rdata !== exp) begin
          miscompares++;
          $display("FAIL rnd_if_data: got req=%b rdata=%h expected 1 %h", if_req, if_rdata, exp);
        end
        if (dm_req) dm_other++;
        if_req = 1'b0;
      end
      if (dm_valid) begin
        exp = dm_we ? 32'h0 : gmem_rd(dm_addr);
        if (dm_we) gmem[dm_addr] = dm_wdata;
        vectors++;
        if (!dm_req || dm_rdata !== exp) begin
          miscompares++;
          $display("FAIL rnd_dm_data: got req=%b rdata=%h expected 1 %h", dm_req, dm_rdata, exp);
        end
        if (if_req) if_other++;
        dm_req = 1'b0;
      end
      vectors++;
      if (if_other > 1 || dm_other > 1 || if_wait > 20 || dm_wait > 20) begin
        miscompares++;
        $display("FAIL rnd_fair: got other=%0d/%0d wait=%0d/%0d expected <=1 <=20",
                 if_other, dm_other, if_wait, dm_wait);
        if_req = 1'b0; dm_req = 1'b0; if_other = 0; dm_other = 0;
        if_wait = 0; dm_wait = 0;
      end
      if (if_req) if_wait++;
      if (dm_req) dm_wait++;
      if (c < 560 && !if_req && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = 32'h200 + 32'($urandom_range(0, 7)) * 4;
        if_wait = 0; if_other = 0;
      end
      if (c < 560 && !dm_req && $urandom_range(0, 2) == 0) begin
        dm_req = 1'b1;
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = 32'h200 + 32'($urandom_range(0, 7)) * 4;
        dm_wdata = $urandom;
        dm_wait = 0; dm_other = 0;
      end
    end
    vectors++;
    if ({if_req, dm_req, timeout_err} !== 3'b000) begin
      miscompares++;
      $display("FAIL rnd_drain: got if=%b dm=%b err=%b expected 0 0 0", if_req, dm_req, timeout_err);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_lone_fetch();
    test_tie();
    test_store();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mem_arb.md
# mem_arb

Single-port memory arbiter that shares one unified instruction/data memory between the IF stage (instruction fetch) and the MEM stage (lw/sw driven by the decoder's `we_dm`/`dm2reg` controls). It serialises requests, supports variable memory latency via `mem_ready`, and returns per-requester valid pulses and stall signals to the pipeline hazard logic. A watchdog aborts transactions that hang.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `TIMEOUT`, 15, max cycles a granted access may wait for `mem_ready` (≥1)

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  fetch request; held with `if_addr` stable until `if_valid`
- `if_addr`  in  AW  fetch address
- `if_rdata`  out  DW  fetched instruction, valid with `if_valid`
- `if_valid`  out  1  one-cycle completion pulse
- `dm_req`  in  1  data request; held with addr/we/wdata stable until `dm_valid`
- `dm_we`  in  1  1 = store, 0 = load
- `dm_addr`  in  AW  data address
- `dm_wdata`  in  DW  store data
- `dm_rdata`  out  DW  load data, valid with `dm_valid`; 0 for stores
- `dm_valid`  out  1  one-cycle completion pulse
- `mem_req`  out  1  memory access strobe
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid when `mem_ready`
- `mem_ready`  in  1  memory completion; sampled only while `mem_req`=1
- `stall_if`  out  1  `if_req & ~if_valid` (combinational)
- `stall_mem`  out  1  `dm_req & ~dm_valid` (combinational)
- `timeout_err`  out  1  sticky watchdog error flag

## Operation
- FSM states: IDLE, GNT_DM, GNT_IF.
- IDLE: arbitrate among eligible requests. A requester whose valid is high this cycle is ineligible.
  - Only DM eligible → GNT_DM; only IF → GNT_IF.
  - Both → grant the one not granted last (`last_gnt` register); `last_gnt` resets to IF, so DM wins the first tie.
- GNT_x: `mem_req`=1; `mem_addr`/`mem_we`/`mem_wdata` driven from the granted requester (`mem_we`=`dm_we` in GNT_DM, 0 in GNT_IF; `mem_wdata`=0 in GNT_IF).
- Completion, cycle with `mem_req & mem_ready`:
  - Capture `mem_rdata` into the granted rdata register (0 for stores).
  - Update `last_gnt`; go to IDLE.
  - Pulse the granted valid on the next cycle.
- Watchdog: counter of width clog2(TIMEOUT+1), cleared on grant, incremented each granted cycle with `mem_ready`=0. On reaching TIMEOUT:
  - Set `timeout_err` (sticky until reset).
  - Abort to IDLE.
  - Next cycle: pulse the granted valid with rdata = 0.
- rdata registers hold their value until the next completion for that requester.
- Requests that drop before valid are a protocol violation; the bench flags them, RTL behaviour is unspecified.

## Timing
- Request visible in IDLE at cycle N → `mem_req` high at N+1 (all `mem_*` outputs registered).
- Zero-wait memory (`mem_ready`=1 at N+1) → valid at N+2. Minimum latency 2 cycles; throughput one access per 2 cycles.
- Each wait cycle adds one cycle.
- Timeout abort: valid at grant + TIMEOUT + 1.
- Valid cycle coincides with IDLE, so the other requester can be granted that same cycle (its `mem_req` rises next cycle).
- Reset (async, any state, including mid-access):
  - State IDLE; `mem_req`, `mem_we`, `mem_addr`, `mem_wdata` = 0.
  - `if_valid`, `dm_valid`, `if_rdata`, `dm_rdata`, `timeout_err` = 0.
  - `last_gnt` = IF, watchdog = 0.
  - No valid pulse is produced for the aborted access.

## Structure
- Shared package `mips_pkg`: `arb_state_t` enum (IDLE, GNT_DM, GNT_IF) and `gnt_t` encoding (GNT_IF=0, GNT_DM=1) used by hazard logic and bench.
- One sub-module: `arb_wdog` (watchdog counter; ports: clear, count enable, TIMEOUT param, `expired` out).
- Arbiter FSM, output registers and rdata capture live in `mem_arb`.

## Test plan
- Lone fetch: `if_req`=1, addr 0x0000_0040, `mem_ready` tied 1, `mem_rdata`=0x2008_0005 → `mem_req` at N+1, `if_valid` and `if_rdata`=0x2008_0005 at N+2; `stall_if` high N..N+1.
- Store: `dm_req`/`dm_we`=1, addr 0x100, wdata 0xDEAD_BEEF, ready after 3 wait cycles → `mem_we`=1 for 4 cycles, `dm_valid` at N+5 with `dm_rdata`=0.
- Tie: `if_req` and `dm_req` both rise at N, ready=1 → DM granted first (valid N+2), IF granted at N+2 (valid N+4); next tie goes to IF.
- Timeout, TIMEOUT=15: load with `mem_ready` held 0 → `timeout_err`=1 and `dm_valid` with `dm_rdata`=0 at grant+16; the following fetch still completes normally and `timeout_err` stays 1.
- Reset mid-access: `rst_n` low during GNT_IF wait → `mem_req` falls immediately; no `if_valid` after release; all outputs 0.
- Back-to-back loads: `dm_req` held across two transactions with addr change after first `dm_valid` → two distinct completions, no spurious extra grant in the valid cycle.
